pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage, directly downstream of the combinational ALU.
- Latches the ALU_equals and ALU_lt flags on flag-writing instructions and resolves conditional and unconditional branches against those stored flags.
- Branch targets come from a programmable lookup table.
- Sequences the PC through the Start → run → halt protocol and drives the instruction-fetch address.

Parameters:
- PC_W, 10, width of the PC in bits (instruction memory depth is 2^PC_W).
- LUT_AW, 5, branch-target LUT index width (2^LUT_AW entries, each PC_W bits).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level; while high, the unit holds in IDLE with PC=0.
- Halt_Req  in  1  decoded halt instruction; valid only in RUN.
- FlagWen  in  1  current instruction writes the flags.
- ALU_equals  in  1  equals flag from the ALU, same cycle.
- ALU_lt  in  1  less-than flag from the ALU, same cycle.
- BrType  in  3  br_type_t: BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_JMP.
- BrIdx  in  LUT_AW  LUT index of the branch target.
- LutWen  in  1  LUT write enable.
- LutWaddr  in  LUT_AW  LUT write index.
- LutWdata  in  PC_W  LUT write data (absolute target).
- PC  out  PC_W  current fetch address, registered.
- FlagEq  out  1  stored equals flag, registered.
- FlagLt  out  1  stored less-than flag, registered.
- Taken  out  1  combinational: branch taken this cycle.
- Running  out  1  registered: state==RUN.
- Done  out  1  registered: state==HALTED.

Behaviour:
- Reset (Reset=1 at an edge):
  - state=IDLE; PC=0; FlagEq=0; FlagLt=0; Done=0; Running=0.
  - All LUT entries are cleared to 0.
  - Reset overrides every other input, in every state, including mid-RUN.
- FSM states: IDLE, RUN, HALTED (pcu_state_t).
- IDLE:
  - PC is forced to 0.
  - Start=0 → RUN at the next edge; PC stays 0 on that edge, so the first fetch address is 0.
  - Start=1 → stay in IDLE.
- RUN, one instruction per cycle:
  - Halt_Req=1 → HALTED; PC is held; Done=1 from the next cycle. Halt has priority over a branch in the same cycle.
  - Otherwise, Taken=1 → PC <= LUT[BrIdx] (absolute target).
  - Otherwise → PC <= PC+1, mod 2^PC_W. Wrap from all-ones to 0 is silent.
  - Start=1 in RUN → IDLE at the next edge (PC=0, Done=0), overriding Halt_Req.
- HALTED:
  - PC and flags are held; Done=1.
  - Start=1 → IDLE; Done clears in the same edge.
  - Halt_Req is ignored.
- Taken decode: Taken=0 outside RUN. In RUN, Taken uses only the registered flags:
  - BR_EQ: FlagEq.
  - BR_NE: !FlagEq.
  - BR_LT: FlagLt.
  - BR_GE: !FlagLt.
  - BR_JMP: 1.
  - BR_NONE and reserved encodings: 0.
- Flag write:
  - In RUN with FlagWen=1 and Halt_Req=0: FlagEq<=ALU_equals, FlagLt<=ALU_lt.
  - Flags are never written in IDLE or HALTED.
- Same-cycle FlagWen and branch: the branch uses the old flags; new flags are visible from the next cycle.
- LUT:
  - Writes are accepted in any state except during Reset.
  - A write and a read of the same index in the same cycle → the read returns the old value.
  - Reads are combinational from the registered array.
- Latency:
  - Branch redirect takes effect at the next edge, with no delay slot.
  - Flags have 1-cycle write-to-use latency.

Decomposition:
- Add to package definitions:
  - typedef enum logic [2:0] br_type_t (BR_NONE=0, BR_EQ=1, BR_NE=2, BR_LT=3, BR_GE=4, BR_JMP=5).
  - typedef enum logic [1:0] pcu_state_t.
  - localparam PC_RESET=0.
- Sub-module branch_lut: 2^LUT_AW×PC_W register array with a synchronous write port, a combinational read port and synchronous clear on Reset.
- FSM, flag registers and Taken decode stay in pc_branch_unit.

Test Plan:
- Reset/start sequence:
  - Stimulus: Reset=1 for 2 cycles, then Start=1 for 3 cycles, then Start=0.
  - Required: PC=0, Done=0, Running=0 throughout reset and Start; Running=1 one cycle after Start falls; PC reads 0,1,2,3 over the following cycles.
- Conditional branch on stored flags:
  - Stimulus: load LUT[3]=0x2A; in RUN at PC=5, assert FlagWen with ALU_equals=1; next cycle BrType=BR_EQ, BrIdx=3.
  - Required: PC=0x2A, Taken=1.
  - Repeat with BR_NE → PC=7.
- Flag hazard:
  - Stimulus: FlagWen=1 with ALU_equals=1 while FlagEq=0, and BR_EQ in the same cycle.
  - Required: not taken, PC+1; FlagEq=1 on the next cycle.
- Halt priority and restart:
  - Stimulus: Halt_Req=1 with BR_JMP at PC=9.
  - Required: PC holds at 9 and Done=1 for ≥3 cycles; Start pulse → PC=0, Done=0, state=IDLE.
- PC wrap:
  - Stimulus: LUT[0]=0x3FF, BR_JMP with BrIdx=0, then BR_NONE.
  - Required: PC=0x3FF, then 0x000, with Running still 1.
- Reset mid-RUN plus LUT read-during-write:
  - Stimulus: LutWen=1 to index 4 with data 0x11 while BR_JMP uses BrIdx=4 holding 0x22.
  - Required: PC=0x22; the next jump to index 4 → PC=0x11.
  - Then Reset=1 in RUN → PC=0, flags 0, LUT[4]=0.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// Shared types and constants for the PC / branch-resolution stage.
package pc_branch_unit_pkg;

    // Branch condition selector, decoded against the stored ALU flags.
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_JMP  = 3'd5
    } br_type_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } pcu_state_t;

    localparam int unsigned PC_RESET = 0;

    // Raw condition result; the caller gates it with the RUN state.
    // Reserved encodings (6, 7) fall to the default and never take.
    function automatic logic br_cond(input logic [2:0] br_type,
                                     input logic       flag_eq,
                                     input logic       flag_lt);
        logic res;
        res = 1'b0;
        case (br_type)
            BR_EQ:   res = flag_eq;
            BR_NE:   res = ~flag_eq;
            BR_LT:   res = flag_lt;
            BR_GE:   res = ~flag_lt;
            BR_JMP:  res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-target table: register array, synchronous write, combinational read.
module branch_lut #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0] mem_q [Depth];

    // Reset clears every entry; otherwise a single write per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Reading the registered array gives old data on a same-index write.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, flag latch and branch resolution with IDLE/RUN/HALTED sequencing.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int unsigned PC_W   = 10,
    parameter int unsigned LUT_AW = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt_Req,
    input  logic              FlagWen,
    input  logic              ALU_equals,
    input  logic              ALU_lt,
    input  logic [2:0]        BrType,
    input  logic [LUT_AW-1:0] BrIdx,
    input  logic              LutWen,
    input  logic [LUT_AW-1:0] LutWaddr,
    input  logic [PC_W-1:0]   LutWdata,
    output logic [PC_W-1:0]   PC,
    output logic              FlagEq,
    output logic              FlagLt,
    output logic              Taken,
    output logic              Running,
    output logic              Done
);

    pcu_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flag_eq_q, flag_eq_d;
    logic            flag_lt_q, flag_lt_d;
    logic            running_q, done_q;
    logic [PC_W-1:0] lut_rdata;
    logic            taken;

    branch_lut #(
        .AW (LUT_AW),
        .DW (PC_W)
    ) u_lut (
        .clk   (Clk),
        .reset (Reset),
        .wen   (LutWen),
        .waddr (LutWaddr),
        .wdata (LutWdata),
        .raddr (BrIdx),
        .rdata (lut_rdata)
    );

    // Branch decision uses only the registered flags, so a same-cycle flag
    // write is not seen until the following instruction.
    always_comb begin
        taken = (state_q == StRun) && br_cond(BrType, flag_eq_q, flag_lt_q);
    end

    // Next-state, next-PC and flag-write logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flag_eq_d = flag_eq_q;
        flag_lt_d = flag_lt_q;
        case (state_q)
            StIdle: begin
                // PC stays at the reset address on the leaving edge, so the
                // first fetch in RUN is address 0.
                pc_d = PC_W'(PC_RESET);
                if (!Start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (Start) begin
                    state_d = StIdle;
                    pc_d    = PC_W'(PC_RESET);
                end else if (Halt_Req) begin
                    state_d = StHalted;
                end else if (taken) begin
                    pc_d = lut_rdata;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
                if (FlagWen && !Halt_Req) begin
                    flag_eq_d = ALU_equals;
                    flag_lt_d = ALU_lt;
                end
            end
            StHalted: begin
                if (Start) begin
                    state_d = StIdle;
                    pc_d    = PC_W'(PC_RESET);
                end
            end
            default: begin
                state_d = StIdle;
                pc_d    = PC_W'(PC_RESET);
            end
        endcase
    end

    // State registers; status outputs are registered copies of the next state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            pc_q      <= PC_W'(PC_RESET);
            flag_eq_q <= 1'b0;
            flag_lt_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flag_eq_q <= flag_eq_d;
            flag_lt_q <= flag_lt_d;
            running_q <= (state_d == StRun);
            done_q    <= (state_d == StHalted);
        end
    end

    assign PC      = pc_q;
    assign FlagEq  = flag_eq_q;
    assign FlagLt  = flag_lt_q;
    assign Taken   = taken;
    assign Running = running_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: one task per scenario, inline checks.
module tb_pc_branch_unit;
    import pc_branch_unit_pkg::*;

    localparam int unsigned PC_W   = 10;
    localparam int unsigned LUT_AW = 5;

    logic              Clk;
    logic              Reset;
    logic              Start;
    logic              Halt_Req;
    logic              FlagWen;
    logic              ALU_equals;
    logic              ALU_lt;
    logic [2:0]        BrType;
    logic [LUT_AW-1:0] BrIdx;
    logic              LutWen;
    logic [LUT_AW-1:0] LutWaddr;
    logic [PC_W-1:0]   LutWdata;
    logic [PC_W-1:0]   PC;
    logic              FlagEq;
    logic              FlagLt;
    logic              Taken;
    logic              Running;
    logic              Done;

    int checks;
    int failures;

    pc_branch_unit #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt_Req   (Halt_Req),
        .FlagWen    (FlagWen),
        .ALU_equals (ALU_equals),
        .ALU_lt     (ALU_lt),
        .BrType     (BrType),
        .BrIdx      (BrIdx),
        .LutWen     (LutWen),
        .LutWaddr   (LutWaddr),
        .LutWdata   (LutWdata),
        .PC         (PC),
        .FlagEq     (FlagEq),
        .FlagLt     (FlagLt),
        .Taken      (Taken),
        .Running    (Running),
        .Done       (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Halt_Req   = 1'b0;
        FlagWen    = 1'b0;
        ALU_equals = 1'b0;
        ALU_lt     = 1'b0;
        BrType     = BR_NONE;
        BrIdx      = '0;
        LutWen     = 1'b0;
        LutWaddr   = '0;
        LutWdata   = '0;
    endtask

    // Start pulse then release: leaves the unit in RUN with PC=0.
    task automatic restart();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (PC !== 10'h000 || Done !== 1'b0 || Running !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: PC=%h Done=%b Running=%b want 000 0 0",
                         PC, Done, Running);
            end
        end
        checks++;
        if (FlagEq !== 1'b0 || FlagLt !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: eq=%b lt=%b want 0 0", FlagEq, FlagLt);
        end
        Reset = 1'b0;
        Start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (PC !== 10'h000 || Done !== 1'b0 || Running !== 1'b0) begin
                failures++;
                $display("FAIL start_hold: PC=%h Done=%b Running=%b want 000 0 0",
                         PC, Done, Running);
            end
        end
        Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (PC !== PC_W'(i) || Running !== 1'b1) begin
                failures++;
                $display("FAIL run_count: PC=%h Running=%b want %h 1", PC, Running, PC_W'(i));
            end
        end
    endtask

    task automatic test_cond_branch();
        // Load LUT[3] while in IDLE.
        LutWen   = 1'b1;
        LutWaddr = 5'd3;
        LutWdata = 10'h02A;
        Start    = 1'b1;
        tick();
        LutWen = 1'b0;
        Start  = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (PC !== 10'h005) begin
            failures++;
            $display("FAIL pre_eq_pc: PC=%h want 005", PC);
        end
        FlagWen    = 1'b1;
        ALU_equals = 1'b1;
        tick();
        FlagWen    = 1'b0;
        ALU_equals = 1'b0;
        BrType     = BR_EQ;
        BrIdx      = 5'd3;
        #1;
        checks++;
        if (Taken !== 1'b1) begin
            failures++;
            $display("FAIL br_eq_taken: Taken=%b want 1", Taken);
        end
        tick();
        BrType = BR_NONE;
        checks++;
        if (PC !== 10'h02A) begin
            failures++;
            $display("FAIL br_eq_pc: PC=%h want 02a", PC);
        end
        // Same flag setup, BR_NE must fall through.
        restart();
        for (int i = 0; i < 5; i++) tick();
        FlagWen    = 1'b1;
        ALU_equals = 1'b1;
        tick();
        FlagWen    = 1'b0;
        ALU_equals = 1'b0;
        BrType     = BR_NE;
        BrIdx      = 5'd3;
        #1;
        checks++;
        if (Taken !== 1'b0) begin
            failures++;
            $display("FAIL br_ne_taken: Taken=%b want 0", Taken);
        end
        tick();
        BrType = BR_NONE;
        checks++;
        if (PC !== 10'h007) begin
            failures++;
            $display("FAIL br_ne_pc: PC=%h want 007", PC);
        end
    endtask

    task automatic test_flag_hazard();
        // Clear FlagEq first (PC 7 -> 8).
        FlagWen    = 1'b1;
        ALU_equals = 1'b0;
        ALU_lt     = 1'b0;
        tick();
        checks++;
        if (FlagEq !== 1'b0 || PC !== 10'h008) begin
            failures++;
            $display("FAIL hazard_setup: eq=%b PC=%h want 0 008", FlagEq, PC);
        end
        ALU_equals = 1'b1;
        BrType     = BR_EQ;
        BrIdx      = 5'd3;
        #1;
        checks++;
        if (Taken !== 1'b0) begin
            failures++;
            $display("FAIL hazard_taken: Taken=%b want 0", Taken);
        end
        tick();
        FlagWen    = 1'b0;
        ALU_equals = 1'b0;
        BrType     = BR_NONE;
        checks++;
        if (PC !== 10'h009 || FlagEq !== 1'b1) begin
            failures++;
            $display("FAIL hazard_after: PC=%h eq=%b want 009 1", PC, FlagEq);
        end
    endtask

    task automatic test_halt();
        Halt_Req = 1'b1;
        BrType   = BR_JMP;
        BrIdx    = 5'd3;
        FlagWen  = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (PC !== 10'h009 || Done !== 1'b1 || Running !== 1'b0 || Taken !== 1'b0) begin
                failures++;
                $display("FAIL halt_hold: PC=%h Done=%b Running=%b Taken=%b want 009 1 0 0",
                         PC, Done, Running, Taken);
            end
            tick();
        end
        checks++;
        if (FlagEq !== 1'b1) begin
            failures++;
            $display("FAIL halt_flags: eq=%b want 1", FlagEq);
        end
        Halt_Req = 1'b0;
        FlagWen  = 1'b0;
        BrType   = BR_NONE;
        Start    = 1'b1;
        tick();
        checks++;
        if (PC !== 10'h000 || Done !== 1'b0 || Running !== 1'b0) begin
            failures++;
            $display("FAIL halt_restart: PC=%h Done=%b Running=%b want 000 0 0",
                     PC, Done, Running);
        end
        Start = 1'b0;
        tick();
        checks++;
        if (PC !== 10'h000 || Running !== 1'b1) begin
            failures++;
            $display("FAIL rerun: PC=%h Running=%b want 000 1", PC, Running);
        end
    endtask

    task automatic test_wrap();
        LutWen   = 1'b1;
        LutWaddr = 5'd0;
        LutWdata = 10'h3FF;
        tick();
        LutWen = 1'b0;
        BrType = BR_JMP;
        BrIdx  = 5'd0;
        tick();
        checks++;
        if (PC !== 10'h3FF || Running !== 1'b1) begin
            failures++;
            $display("FAIL wrap_jump: PC=%h Running=%b want 3ff 1", PC, Running);
        end
        BrType = BR_NONE;
        tick();
        checks++;
        if (PC !== 10'h000 || Running !== 1'b1) begin
            failures++;
            $display("FAIL wrap_inc: PC=%h Running=%b want 000 1", PC, Running);
        end
    endtask

    task automatic test_rdw_and_reset();
        LutWen   = 1'b1;
        LutWaddr = 5'd4;
        LutWdata = 10'h022;
        tick();
        LutWdata = 10'h011;
        BrType   = BR_JMP;
        BrIdx    = 5'd4;
        tick();
        LutWen = 1'b0;
        checks++;
        if (PC !== 10'h022) begin
            failures++;
            $display("FAIL rdw_old: PC=%h want 022", PC);
        end
        tick();
        BrType = BR_NONE;
        checks++;
        if (PC !== 10'h011) begin
            failures++;
            $display("FAIL rdw_new: PC=%h want 011", PC);
        end
        FlagWen    = 1'b1;
        ALU_equals = 1'b1;
        ALU_lt     = 1'b1;
        tick();
        FlagWen = 1'b0;
        checks++;
        if (PC !== 10'h012 || FlagEq !== 1'b1 || FlagLt !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: PC=%h eq=%b lt=%b want 012 1 1", PC, FlagEq, FlagLt);
        end
        Reset  = 1'b1;
        BrType = BR_JMP;
        tick();
        checks++;
        if (PC !== 10'h000 || FlagEq !== 1'b0 || FlagLt !== 1'b0 || Running !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: PC=%h eq=%b lt=%b Running=%b want 000 0 0 0",
                     PC, FlagEq, FlagLt, Running);
        end
        Reset  = 1'b0;
        BrType = BR_NONE;
        tick();
        // Jump through cleared LUT[4]: target 0, not PC+1 and not 0x11.
        BrType = BR_JMP;
        BrIdx  = 5'd4;
        tick();
        BrType = BR_NONE;
        checks++;
        if (PC !== 10'h000) begin
            failures++;
            $display("FAIL lut_cleared: PC=%h want 000", PC);
        end
    endtask

    task automatic test_lt_ge();
        LutWen     = 1'b1;
        LutWaddr   = 5'd5;
        LutWdata   = 10'h050;
        FlagWen    = 1'b1;
        ALU_equals = 1'b0;
        ALU_lt     = 1'b1;
        tick();
        LutWen  = 1'b0;
        FlagWen = 1'b0;
        BrType  = BR_GE;
        BrIdx   = 5'd5;
        tick();
        checks++;
        if (PC !== 10'h002) begin
            failures++;
            $display("FAIL br_ge_pc: PC=%h want 002", PC);
        end
        BrType = BR_LT;
        tick();
        checks++;
        if (PC !== 10'h050) begin
            failures++;
            $display("FAIL br_lt_pc: PC=%h want 050", PC);
        end
        BrType = 3'd7;
        #1;
        checks++;
        if (Taken !== 1'b0) begin
            failures++;
            $display("FAIL br_rsvd_taken: Taken=%b want 0", Taken);
        end
        tick();
        BrType = BR_NONE;
        checks++;
        if (PC !== 10'h051) begin
            failures++;
            $display("FAIL br_rsvd_pc: PC=%h want 051", PC);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        Start    = 1'b0;
        idle_inputs();
        test_reset();
        test_cond_branch();
        test_flag_hazard();
        test_halt();
        test_wrap();
        test_rdw_and_reset();
        test_lt_ge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
